micro_exec_core: RTL and testbench
==================================

Name: micro_exec_core

Overview:
- Back half of the pipelined microprogrammed CPU: instruction decode register, microcode control unit (CU), and ALU/branch stage.
- Takes 32-bit instructions from fetch and sequences 1–3 microwords per instruction from the external micro-ROM.
- Drives the register file and data memory, and reports branch outcomes and pipeline flushes back to fetch.

Parameters:
- DW, 16, datapath and register width.
- AW, 8, register, memory and micro-ROM address width.
- NOP_UADDR, 67, micro-ROM address of the NOP microword.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- fetch_idecode_interface  in  50  [49] valid, [48] reserved, [47:32] pc, [31:0] instr.
- dec_ready  out  1  decode can accept an instruction this cycle.
- exec_ready  out  1  CU can accept a decoded instruction (low during multi-word sequences).
- flush_pipeline  out  1  branch/jump taken, asserted in the ALU cycle.
- alu_fetch_interface  out  19  [18] resolved, [17] taken, [16] 0, [15:0] target.
- micro_code_addr_out  out  8  micro-ROM address of the continuing word.
- micro_code_in_normal  in  32  word at micro_code_addr_out, combinational.
- micro_code_addr_speculative_fetch  out  8  entry address of the instruction held in decode.
- micro_code_in_speculative  in  32  word at the speculative address.
- micro_code_out_external_mem  out  32  microword currently in the ALU stage.
- alu_regfile_address_out_1, alu_regfile_address_out_2  out  8  register read addresses.
- alu_regfile_in_1, alu_regfile_in_2  in  16  combinational register read data.
- alu_regfile_write_en_out  out  1  register write enable.
- alu_regfile_address_out  out  8  destination register.
- alu_result  out  16  register/memory write data.
- alu_memory_address_out  out  8  memory address.
- alu_memory_in  in  16  memory read data, valid one edge after the address.
- alu_memory_write_en_out  out  1  memory write enable.

Behaviour:
- Instruction fields:
  - [31:24] opcode.
  - f1 = [23:16]: rs1 / mem address / jump target.
  - f2 = [15:8]: rs2 / immediate.
  - f3 = [7:0]: rd / beq target.
- Opcode map (entry address, microword count):
  - 0x01..0x07 add, sub, and, or, xor, sll, srl: entry k-1, 1 word.
  - 0x11..0x17 mem1 variants: entry 7+3(k-1), 3 words.
  - 0x21..0x27 mem2 variants: entry 10+3(k-1), 3 words.
  - 0x31..0x37 immediate variants: entry 49+(k-1), 1 word.
  - 0x40 jump: 56, 1 word.
  - 0x60 beq: 57, 1 word.
  - 0x80 load: 58, 3 words.
  - 0x81 store: 63, 2 words.
  - 0x82 store immediate: 65, 2 words.
  - Any other opcode: NOP_UADDR, 1 word.
- Microword bit assignments:
  - [0] write register rd.
  - [1] write memory.
  - [2] memory-address select: 0 = f1, 1 = f2.
  - [4] load the memory-address register.
  - [6] B = RF[f2]; [7] A = RF[f1].
  - [8] B = memory data; [9] A = memory data.
  - [20] B = zero-extended f2.
  - [22] unconditional jump.
  - [15:12] ALU op: 0 = A|B (unselected operand reads 0), 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 sll by B[3:0], 7 srl by B[3:0], 12 = beq (branch if A==B).
  - All other bits ignored.
- Arithmetic: 16-bit, wraps modulo 2^16, no flags.
- Decode stage:
  - Registers valid/pc/instr and the table lookup when valid && dec_ready.
  - dec_ready = exec_ready || !decode_valid.
- CU stage:
  - Accepting a new instruction: the speculative word is issued into the CU→ALU register.
  - Later words: micro_code_addr_out = current+1, normal word issued.
  - exec_ready is low until the last word has issued.
- ALU stage:
  - Register reads, operation and alu_result are all combinational.
  - The register file and memory write at the end of that cycle, so back-to-back dependent instructions need no forwarding.
  - The memory-address register loads the selected field when bit [4] is set; alu_memory_address_out shows the selected field in that cycle and the register value otherwise.
- Latency: instruction accepted at edge n, first microword in the ALU at n+1, register written at edge n+2.
- Branches:
  - beq compares A and B; a jump microword is always taken.
  - While a branch is in the ALU, alu_fetch_interface resolved=1, taken, and target = {8'b0, f1} for jump or {8'b0, f3} for beq. Fetch maps the target to instruction index target>>1.
  - When taken, flush_pipeline=1 for that cycle. At the closing edge the decode register is invalidated and the CU loads NOP_UADDR with any in-progress sequence aborted.
- Reset: all valids 0, CU holds the NOP word, every output and write enable 0, and dec_ready, exec_ready = 1.
- A flush has priority over a simultaneous accept.

Decomposition:
- Package micro_exec_pkg: opcode constants, microword bit indices, ALU-op codes, NOP_UADDR, and an opcode→(entry, length) function.
- A natural sub-module is micro_exec_alu (combinational datapath plus branch compare).

Test Plan:
- Register init R0=1, R2=3, R3=5, R8=0xA.
  - add 0x01000200 → R0=4.
  - Then sub 0x02010300 → R0=R1-R3 = 2-5 = 0xFFFD.
  - Then 0x01000801 → R1 = 0xFFFD+0xA = 0x0007.
- Load 0x80080001 with mem[8]=0xF → exec_ready low for 2 cycles, then R1=0x000F.
- Jump 0x40100000 → flush pulse and alu_fetch_interface = {1,1,0,0x0010}; the following instruction is not executed.
- beq 0x60030304 → taken, target 0x0004. With R3≠R4 → resolved=1, taken=0, no flush.
- Store 0x81000000 with R0=0xFFFD → memory write enable for 1 cycle, address 0, data 0xFFFD.
- Assert rst during a load sequence → outputs 0 immediately, no register/memory write, ready high after release.

Source files
------------

// File: rtl/micro_exec_pkg.sv
// Shared definitions for the micro_exec_core back end: opcode map, microword
// bit positions, ALU operation codes and the opcode-to-microcode lookup.
package micro_exec_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam logic [7:0] NOP_ENTRY = 8'd67;

  localparam logic [7:0] OP_ALU_BASE  = 8'h01;
  localparam logic [7:0] OP_MEM1_BASE = 8'h11;
  localparam logic [7:0] OP_MEM2_BASE = 8'h21;
  localparam logic [7:0] OP_IMM_BASE  = 8'h31;
  localparam logic [7:0] OP_JUMP      = 8'h40;
  localparam logic [7:0] OP_BEQ       = 8'h60;
  localparam logic [7:0] OP_LOAD      = 8'h80;
  localparam logic [7:0] OP_STORE     = 8'h81;
  localparam logic [7:0] OP_STORE_IMM = 8'h82;
  localparam logic [7:0] VARIANTS     = 8'd7;

  localparam int UB_WR_REG = 0;
  localparam int UB_WR_MEM = 1;
  localparam int UB_MA_SEL = 2;
  localparam int UB_MA_LD  = 4;
  localparam int UB_B_RF   = 6;
  localparam int UB_A_RF   = 7;
  localparam int UB_B_MEM  = 8;
  localparam int UB_A_MEM  = 9;
  localparam int UB_B_IMM  = 20;
  localparam int UB_JUMP   = 22;
  localparam int UB_OP_LO  = 12;
  localparam int UB_OP_HI  = 15;

  typedef enum logic [3:0] {
    ALU_PASS = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_BEQ  = 4'd12
  } alu_op_e;

  typedef struct packed {
    logic [7:0] entry;
    logic [1:0] len;
  } uinfo_t;

  // Entry address and microword count for an opcode; unknown opcodes run the NOP word.
  function automatic uinfo_t lookup_opcode(input logic [7:0] opcode, input logic [7:0] nop_uaddr);
    uinfo_t     info;
    logic [7:0] k;
    info.entry = nop_uaddr;
    info.len   = 2'd1;
    k          = '0;
    if (opcode >= OP_ALU_BASE && opcode < OP_ALU_BASE + VARIANTS) begin
      k          = opcode - OP_ALU_BASE;
      info.entry = k;
    end else if (opcode >= OP_MEM1_BASE && opcode < OP_MEM1_BASE + VARIANTS) begin
      k          = opcode - OP_MEM1_BASE;
      info.entry = 8'd7 + k * 8'd3;
      info.len   = 2'd3;
    end else if (opcode >= OP_MEM2_BASE && opcode < OP_MEM2_BASE + VARIANTS) begin
      k          = opcode - OP_MEM2_BASE;
      info.entry = 8'd10 + k * 8'd3;
      info.len   = 2'd3;
    end else if (opcode >= OP_IMM_BASE && opcode < OP_IMM_BASE + VARIANTS) begin
      k          = opcode - OP_IMM_BASE;
      info.entry = 8'd49 + k;
    end else begin
      case (opcode)
        OP_JUMP:      info.entry = 8'd56;
        OP_BEQ:       info.entry = 8'd57;
        OP_LOAD:      begin info.entry = 8'd58; info.len = 2'd3; end
        OP_STORE:     begin info.entry = 8'd63; info.len = 2'd2; end
        OP_STORE_IMM: begin info.entry = 8'd65; info.len = 2'd2; end
        default:      ;
      endcase
    end
    return info;
  endfunction

endpackage

// File: rtl/micro_exec_alu.sv
// Combinational ALU-stage datapath: operand selection from the microword,
// the arithmetic/logic result and the branch compare.
module micro_exec_alu
  import micro_exec_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic [31:0]   uword,
  input  logic [DW-1:0] rf_a,
  input  logic [DW-1:0] rf_b,
  input  logic [DW-1:0] mem_data,
  input  logic [7:0]    imm,
  output logic [DW-1:0] result,
  output logic          resolved,
  output logic          taken
);

  logic [DW-1:0] a;
  logic [DW-1:0] b;
  alu_op_e       op;
  logic          is_beq;
  logic          is_jump;
  logic          unused_word;

  assign op          = alu_op_e'(uword[UB_OP_HI:UB_OP_LO]);
  assign unused_word = ^{uword[31:23], uword[21], uword[19:16], uword[11:10], uword[5:0]};

  // NOTE: every output of this block is given a default first so no path can infer a latch.
  always_comb begin
    a = '0;
    b = '0;
    if (uword[UB_A_RF])       a = rf_a;
    else if (uword[UB_A_MEM]) a = mem_data;
    if (uword[UB_B_RF])       b = rf_b;
    else if (uword[UB_B_MEM]) b = mem_data;
    else if (uword[UB_B_IMM]) b = {{(DW-8){1'b0}}, imm};

    result = '0;
    case (op)
      ALU_PASS: result = a | b;
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << b[3:0];
      ALU_SRL:  result = a >> b[3:0];
      default:  result = '0;
    endcase
  end

  assign is_beq   = (op == ALU_BEQ);
  assign is_jump  = uword[UB_JUMP];
  assign resolved = is_beq | is_jump;
  assign taken    = is_jump | (is_beq && (a == b));

endmodule

// File: rtl/micro_exec_core.sv
// Decode register, microcode sequencer and ALU/branch stage of the pipelined
// microprogrammed CPU.
module micro_exec_core
  import micro_exec_pkg::*;
#(
  parameter int         DW        = DATA_W,
  parameter int         AW        = ADDR_W,
  parameter logic [7:0] NOP_UADDR = NOP_ENTRY
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [49:0]   fetch_idecode_interface,
  output logic          dec_ready,
  output logic          exec_ready,
  output logic          flush_pipeline,
  output logic [18:0]   alu_fetch_interface,
  output logic [AW-1:0] micro_code_addr_out,
  input  logic [31:0]   micro_code_in_normal,
  output logic [AW-1:0] micro_code_addr_speculative_fetch,
  input  logic [31:0]   micro_code_in_speculative,
  output logic [31:0]   micro_code_out_external_mem,
  output logic [AW-1:0] alu_regfile_address_out_1,
  output logic [AW-1:0] alu_regfile_address_out_2,
  input  logic [DW-1:0] alu_regfile_in_1,
  input  logic [DW-1:0] alu_regfile_in_2,
  output logic          alu_regfile_write_en_out,
  output logic [AW-1:0] alu_regfile_address_out,
  output logic [DW-1:0] alu_result,
  output logic [AW-1:0] alu_memory_address_out,
  input  logic [DW-1:0] alu_memory_in,
  output logic          alu_memory_write_en_out
);

  logic          dec_valid;
  logic [15:0]   dec_pc;
  logic [31:0]   dec_instr;
  uinfo_t        dec_info;
  logic [31:0]   alu_word;
  logic [31:0]   alu_instr;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] mar;
  logic [1:0]    remaining;
  logic          accept;
  logic          resolved;
  logic          taken;
  logic [7:0]    f1, f2, f3;
  logic [7:0]    ma_field;
  logic [7:0]    target;
  logic          unused_bits;

  assign exec_ready = (remaining == 2'd0);
  assign dec_ready  = exec_ready || !dec_valid;
  assign accept     = dec_valid && exec_ready && !flush_pipeline;

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_valid <= 1'b0;
      dec_pc    <= '0;
      dec_instr <= '0;
      dec_info  <= '0;
    end else if (flush_pipeline) begin
      dec_valid <= 1'b0;
    end else if (fetch_idecode_interface[49] && dec_ready) begin
      dec_valid <= 1'b1;
      dec_pc    <= fetch_idecode_interface[47:32];
      dec_instr <= fetch_idecode_interface[31:0];
      dec_info  <= lookup_opcode(fetch_idecode_interface[31:24], NOP_UADDR);
    end else if (accept) begin
      dec_valid <= 1'b0;
    end
  end

  // An all-zero microword has no side effects, so it doubles as the bubble after a flush or when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_word  <= '0;
      alu_instr <= '0;
      cur_addr  <= NOP_UADDR;
      remaining <= '0;
    end else if (flush_pipeline) begin
      alu_word  <= '0;
      alu_instr <= '0;
      cur_addr  <= NOP_UADDR;
      remaining <= '0;
    end else if (remaining != 2'd0) begin
      alu_word  <= micro_code_in_normal;
      cur_addr  <= cur_addr + 1'b1;
      remaining <= remaining - 2'd1;
    end else if (accept) begin
      alu_word  <= micro_code_in_speculative;
      alu_instr <= dec_instr;
      cur_addr  <= dec_info.entry;
      remaining <= dec_info.len - 2'd1;
    end else begin
      alu_word  <= '0;
    end
  end

  assign micro_code_addr_out               = (remaining != 2'd0) ? cur_addr + 1'b1 : '0;
  assign micro_code_addr_speculative_fetch = dec_info.entry;
  assign micro_code_out_external_mem       = alu_word;

  assign f1 = alu_instr[23:16];
  assign f2 = alu_instr[15:8];
  assign f3 = alu_instr[7:0];

  assign ma_field = alu_word[UB_MA_SEL] ? f2 : f1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     mar <= '0;
    else if (alu_word[UB_MA_LD]) mar <= ma_field;
  end

  assign alu_memory_address_out    = alu_word[UB_MA_LD] ? ma_field : mar;
  assign alu_memory_write_en_out   = alu_word[UB_WR_MEM];
  assign alu_regfile_write_en_out  = alu_word[UB_WR_REG];
  assign alu_regfile_address_out   = f3;
  assign alu_regfile_address_out_1 = f1;
  assign alu_regfile_address_out_2 = f2;

  micro_exec_alu #(.DW(DW)) u_alu (
    .uword    (alu_word),
    .rf_a     (alu_regfile_in_1),
    .rf_b     (alu_regfile_in_2),
    .mem_data (alu_memory_in),
    .imm      (f2),
    .result   (alu_result),
    .resolved (resolved),
    .taken    (taken)
  );

  assign target              = alu_word[UB_JUMP] ? f1 : f3;
  assign flush_pipeline      = taken;
  assign alu_fetch_interface = {resolved, taken, 1'b0, resolved ? {8'h00, target} : 16'h0000};

  assign unused_bits = ^{fetch_idecode_interface[48], dec_pc, alu_instr[31:24]};

endmodule

// File: tb/tb_micro_exec_core.sv
// Directed bench for micro_exec_core with behavioural micro-ROM, register
// file and data memory around the DUT.
module tb_micro_exec_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [49:0] fetch;
  logic        dec_ready, exec_ready, flush_pipeline;
  logic [18:0] alu_fetch_interface;
  logic [7:0]  micro_code_addr_out, micro_code_addr_speculative_fetch;
  logic [31:0] micro_code_in_normal, micro_code_in_speculative, micro_code_out_external_mem;
  logic [7:0]  rf_addr_1, rf_addr_2, rf_waddr, mem_addr;
  logic [15:0] rf_in_1, rf_in_2, alu_result, mem_q;
  logic        rf_we, mem_we;

  logic [15:0] rf  [256];
  logic [15:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [7:0] a);
    logic [31:0] w;
    w = '0;
    if (a <= 8'd6) begin
      w = 32'h0000_00C1;
      w[15:12] = a[3:0] + 4'd1;
    end else if (a >= 8'd49 && a <= 8'd55) begin
      w = 32'h0010_0081;
      w[15:12] = 4'(a - 8'd48);
    end else begin
      case (a)
        8'd56:   w = 32'h0040_0000;
        8'd57:   w = 32'h0000_C0C0;
        8'd58:   w = 32'h0000_0010;
        8'd60:   w = 32'h0000_0201;
        8'd63:   w = 32'h0000_0010;
        8'd64:   w = 32'h0000_0082;
        8'd65:   w = 32'h0000_0010;
        8'd66:   w = 32'h0010_0002;
        default: w = '0;
      endcase
    end
    return w;
  endfunction

  assign micro_code_in_normal      = rom(micro_code_addr_out);
  assign micro_code_in_speculative = rom(micro_code_addr_speculative_fetch);
  assign rf_in_1 = rf[rf_addr_1];
  assign rf_in_2 = rf[rf_addr_2];

  always @(posedge clk) begin
    if (rf_we)  rf[rf_waddr]  <= alu_result;
    if (mem_we) mem[mem_addr] <= alu_result;
    mem_q <= mem[mem_addr];
  end

  micro_exec_core dut (
    .clk                               (clk),
    .rst                               (rst),
    .fetch_idecode_interface           (fetch),
    .dec_ready                         (dec_ready),
    .exec_ready                        (exec_ready),
    .flush_pipeline                    (flush_pipeline),
    .alu_fetch_interface               (alu_fetch_interface),
    .micro_code_addr_out               (micro_code_addr_out),
    .micro_code_in_normal              (micro_code_in_normal),
    .micro_code_addr_speculative_fetch (micro_code_addr_speculative_fetch),
    .micro_code_in_speculative         (micro_code_in_speculative),
    .micro_code_out_external_mem       (micro_code_out_external_mem),
    .alu_regfile_address_out_1         (rf_addr_1),
    .alu_regfile_address_out_2         (rf_addr_2),
    .alu_regfile_in_1                  (rf_in_1),
    .alu_regfile_in_2                  (rf_in_2),
    .alu_regfile_write_en_out          (rf_we),
    .alu_regfile_address_out           (rf_waddr),
    .alu_result                        (alu_result),
    .alu_memory_address_out            (mem_addr),
    .alu_memory_in                     (mem_q),
    .alu_memory_write_en_out           (mem_we)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction and returns #1 after the edge that captured it into decode.
  task automatic send(input logic [31:0] ins);
    bit got;
    got   = 1'b0;
    fetch = {1'b1, 1'b0, 16'h0000, ins};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dec_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout instr=%h dec_ready never rose", ins);
      fetch = '0;
    end else begin
      @(posedge clk);
      #1;
      fetch = '0;
    end
  endtask

  task automatic test_reset();
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL rst_dec_ready got=%b exp=1", dec_ready); end
    checks++; if (exec_ready !== 1'b1) begin errors++; $display("FAIL rst_exec_ready got=%b exp=1", exec_ready); end
    checks++; if ({flush_pipeline, rf_we, mem_we} !== 3'b000) begin errors++; $display("FAIL rst_enables got=%b exp=000", {flush_pipeline, rf_we, mem_we}); end
    checks++; if (alu_fetch_interface !== 19'h0) begin errors++; $display("FAIL rst_fetch_if got=%h exp=0", alu_fetch_interface); end
    checks++; if (micro_code_out_external_mem !== 32'h0) begin errors++; $display("FAIL rst_uword got=%h exp=0", micro_code_out_external_mem); end
    checks++; if ({alu_result, mem_addr, micro_code_addr_out} !== 32'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", {alu_result, mem_addr, micro_code_addr_out}); end
  endtask

  task automatic test_arith();
    send(32'h0100_0200);
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 8'h00) begin errors++; $display("FAIL add_write got we=%b rd=%h exp we=1 rd=00", rf_we, rf_waddr); end
    checks++; if (alu_result !== 16'h0004) begin errors++; $display("FAIL add_result got=%h exp=0004", alu_result); end
    send(32'h0201_0300);
    send(32'h0100_0801);
    repeat (3) tick();
    checks++; if (rf[0] !== 16'hFFFD) begin errors++; $display("FAIL sub_wrap got=%h exp=fffd", rf[0]); end
    checks++; if (rf[1] !== 16'h0007) begin errors++; $display("FAIL dependent_add got=%h exp=0007", rf[1]); end
  endtask

  task automatic test_load();
    send(32'h8008_0001);
    tick();
    checks++; if (exec_ready !== 1'b0) begin errors++; $display("FAIL load_busy1 got=%b exp=0", exec_ready); end
    checks++; if (mem_addr !== 8'h08 || micro_code_out_external_mem !== 32'h10) begin errors++; $display("FAIL load_addr got addr=%h uw=%h exp addr=08 uw=00000010", mem_addr, micro_code_out_external_mem); end
    tick();
    checks++; if (exec_ready !== 1'b0) begin errors++; $display("FAIL load_busy2 got=%b exp=0", exec_ready); end
    tick();
    checks++; if (exec_ready !== 1'b1) begin errors++; $display("FAIL load_ready got=%b exp=1", exec_ready); end
    checks++; if (rf_we !== 1'b1 || alu_result !== 16'h000F) begin errors++; $display("FAIL load_data got we=%b data=%h exp we=1 data=000f", rf_we, alu_result); end
    tick();
    checks++; if (rf[1] !== 16'h000F) begin errors++; $display("FAIL load_rf got=%h exp=000f", rf[1]); end
  endtask

  task automatic test_jump();
    send(32'h4010_0000);
    send(32'h0102_0203);
    checks++; if (flush_pipeline !== 1'b1) begin errors++; $display("FAIL jump_flush got=%b exp=1", flush_pipeline); end
    checks++; if (alu_fetch_interface !== 19'h60010) begin errors++; $display("FAIL jump_fetch_if got=%h exp=60010", alu_fetch_interface); end
    tick();
    checks++; if (flush_pipeline !== 1'b0) begin errors++; $display("FAIL jump_flush_pulse got=%b exp=0", flush_pipeline); end
    repeat (3) tick();
    checks++; if (rf[3] !== 16'h0005) begin errors++; $display("FAIL jump_shadow got=%h exp=0005", rf[3]); end
  endtask

  task automatic test_beq();
    send(32'h6003_0404);
    tick();
    checks++; if (alu_fetch_interface !== 19'h40004 || flush_pipeline !== 1'b0) begin errors++; $display("FAIL beq_not_taken got if=%h fl=%b exp if=40004 fl=0", alu_fetch_interface, flush_pipeline); end
    send(32'h6003_0304);
    tick();
    checks++; if (alu_fetch_interface !== 19'h60004 || flush_pipeline !== 1'b1) begin errors++; $display("FAIL beq_taken got if=%h fl=%b exp if=60004 fl=1", alu_fetch_interface, flush_pipeline); end
    tick();
  endtask

  task automatic test_imm();
    send(32'h3603_0404);
    tick();
    checks++; if (alu_result !== 16'h0050) begin errors++; $display("FAIL imm_sll got=%h exp=0050", alu_result); end
    tick();
    checks++; if (rf[4] !== 16'h0050) begin errors++; $display("FAIL imm_rf got=%h exp=0050", rf[4]); end
  endtask

  task automatic test_store();
    send(32'h8100_0000);
    tick();
    checks++; if (mem_we !== 1'b0 || exec_ready !== 1'b0) begin errors++; $display("FAIL store_w1 got we=%b rdy=%b exp we=0 rdy=0", mem_we, exec_ready); end
    tick();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h00 || alu_result !== 16'hFFFD) begin errors++; $display("FAIL store_w2 got we=%b a=%h d=%h exp we=1 a=00 d=fffd", mem_we, mem_addr, alu_result); end
    tick();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL store_single got=%b exp=0", mem_we); end
    checks++; if (mem[0] !== 16'hFFFD) begin errors++; $display("FAIL store_mem got=%h exp=fffd", mem[0]); end
  endtask

  task automatic test_reset_mid_load();
    send(32'h8008_0002);
    tick();
    rst = 1'b1;
    #1;
    checks++; if ({rf_we, mem_we, flush_pipeline} !== 3'b000) begin errors++; $display("FAIL midrst_enables got=%b exp=000", {rf_we, mem_we, flush_pipeline}); end
    checks++; if (micro_code_out_external_mem !== 32'h0 || mem_addr !== 8'h00) begin errors++; $display("FAIL midrst_outputs got uw=%h a=%h exp 0", micro_code_out_external_mem, mem_addr); end
    checks++; if (exec_ready !== 1'b1) begin errors++; $display("FAIL midrst_exec_ready got=%b exp=1", exec_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) tick();
    checks++; if (rf[2] !== 16'h0003) begin errors++; $display("FAIL midrst_no_write got=%h exp=0003", rf[2]); end
    checks++; if (dec_ready !== 1'b1 || exec_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b%b exp=11", dec_ready, exec_ready); end
  endtask

  initial begin
    rst   = 1'b1;
    fetch = '0;
    for (int i = 0; i < 256; i++) begin
      rf[i]  <= '0;
      mem[i] <= '0;
    end
    rf[0]  <= 16'h0001;
    rf[1]  <= 16'h0002;
    rf[2]  <= 16'h0003;
    rf[3]  <= 16'h0005;
    rf[8]  <= 16'h000A;
    mem[8] <= 16'h000F;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    test_arith();
    test_load();
    test_jump();
    test_beq();
    test_imm();
    test_store();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
